// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - shared states, light encodings and request priority helper
package intersection_pkg;

  typedef enum logic [2:0] {
    ST_LEFT,
    ST_GREEN,
    ST_YELLOW,
    ST_CLEAR,
    ST_PREEMPT
  } state_t;

  // Nibble order is {left, green, yellow, red}
  localparam logic [3:0] LIGHT_LEFT   = 4'b1001;
  localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
  localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
  localparam logic [3:0] LIGHT_RED    = 4'b0001;

  localparam int MAX_PHASES = 32;

  // Lowest set index wins; returns 0 when nothing is set
  function automatic logic [4:0] lowest_set(input logic [MAX_PHASES-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_PHASES - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intersection_if.sv
// rtl/intersection_if.sv - emergency request and signal-head bundle of one intersection
interface intersection_if #(
  parameter int N_PHASES = 2
);
  localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;

  logic [N_PHASES-1:0]   emergency;
  logic [4*N_PHASES-1:0] lights;
  logic [PW-1:0]         phase;
  logic                  preempt;

  modport master (output emergency, input lights, input phase, input preempt);
  modport slave  (input emergency, output lights, output phase, output preempt);
endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - dwell counter; done flags the last cycle of the selected duration
module dwell_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == dur - CNT_W'(1));

endmodule

// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - multi-phase light sequencer with emergency pre-emption
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int N_PHASES   = 2,
  parameter int LEFT_CYC   = 5,
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int CLEAR_CYC  = 1,
  parameter int CNT_W      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  intersection_if.slave io
);

  localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;

  state_t                state, state_n;
  logic [PW-1:0]         phase_r, phase_n, target, target_n, next_phase, req_idx;
  logic                  pend, pend_n, post, post_n;
  logic                  emer_any, pend_set, done;
  logic [CNT_W-1:0]      dur;
  logic [4*N_PHASES-1:0] lights;

  assign emer_any   = |io.emergency;
  assign req_idx    = PW'(lowest_set(MAX_PHASES'(io.emergency)));
  assign pend_set   = emer_any && !pend && (state != ST_PREEMPT);
  assign target_n   = pend_set ? req_idx : target;
  assign next_phase = (phase_r == PW'(N_PHASES - 1)) ? '0 : phase_r + PW'(1);

  always_comb begin
    dur = CNT_W'(CLEAR_CYC);
    case (state)
      ST_LEFT:   dur = CNT_W'(LEFT_CYC);
      ST_GREEN:  dur = CNT_W'(GREEN_CYC);
      ST_YELLOW: dur = CNT_W'(YELLOW_CYC);
      default:   dur = CNT_W'(CLEAR_CYC);
    endcase
  end

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_n != state),
    .en    (state != ST_PREEMPT),
    .dur   (dur),
    .done  (done)
  );

  always_comb begin
    state_n = state;
    phase_n = phase_r;
    pend_n  = pend | pend_set;
    post_n  = post;
    case (state)
      ST_LEFT, ST_GREEN: begin
        // A pending request cuts the dwell short: serve in place or hand off through yellow
        if (pend) begin
          state_n = (phase_r == target) ? ST_PREEMPT : ST_YELLOW;
        end else if (done) begin
          state_n = (state == ST_LEFT) ? ST_GREEN : ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (done) state_n = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (done) begin
          post_n = 1'b0;
          if (pend || emer_any) begin
            state_n = ST_PREEMPT;
            phase_n = target_n;
          end else begin
            state_n = ST_LEFT;
            phase_n = next_phase;
          end
        end
      end
      ST_PREEMPT: begin
        if (!io.emergency[target]) begin
          state_n = ST_YELLOW;
          post_n  = 1'b1;
        end
      end
      default: state_n = ST_LEFT;
    endcase
    if (state_n == ST_PREEMPT) pend_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LEFT;
      phase_r <= '0;
      target  <= '0;
      pend    <= 1'b0;
      post    <= 1'b0;
    end else begin
      state   <= state_n;
      phase_r <= phase_n;
      target  <= target_n;
      pend    <= pend_n;
      post    <= post_n;
    end
  end

  // Moore decode: only the owning approach ever leaves red
  always_comb begin
    for (int p = 0; p < N_PHASES; p++) begin
      lights[4*p +: 4] = LIGHT_RED;
      if (PW'(p) == phase_r) begin
        case (state)
          ST_LEFT:    lights[4*p +: 4] = LIGHT_LEFT;
          ST_GREEN:   lights[4*p +: 4] = LIGHT_GREEN;
          ST_YELLOW:  lights[4*p +: 4] = LIGHT_YELLOW;
          ST_PREEMPT: lights[4*p +: 4] = LIGHT_GREEN;
          default:    lights[4*p +: 4] = LIGHT_RED;
        endcase
      end
    end
  end

  assign io.lights  = lights;
  assign io.phase   = phase_r;
  assign io.preempt = pend | (state == ST_PREEMPT) | post;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb/tb_intersection_ctrl.sv - scoreboard bench for two- and four-approach controllers
module tb_intersection_ctrl;

  localparam int L = 0, G = 1, Y = 2, C = 3, P = 4;

  typedef struct {
    int dut;
    int st;
    int ph;
    bit pre;
  } exp_t;

  logic clk = 1'b0;
  logic rst2_n, rst4_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cur = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  intersection_if #(.N_PHASES(2)) bus2 ();
  intersection_if #(.N_PHASES(4)) bus4 ();

  intersection_ctrl #(.N_PHASES(2)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .io    (bus2.slave)
  );

  intersection_ctrl #(.N_PHASES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .io    (bus4.slave)
  );

  function automatic logic [3:0] code(input int st);
    case (st)
      L:       return 4'b1001;
      G:       return 4'b0100;
      Y:       return 4'b0010;
      P:       return 4'b0100;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [15:0] exp_lights(input int n, input int st, input int ph);
    logic [15:0] r;
    r = '0;
    for (int p = 0; p < n; p++) r[4*p +: 4] = (p == ph) ? code(st) : 4'b0001;
    return r;
  endfunction

  task automatic check_inv(input int id, input int n, input logic [15:0] lt);
    int nonred;
    bit bad;
    nonred = 0;
    bad = 0;
    for (int p = 0; p < n; p++) begin
      if (lt[4*p +: 4] != 4'b0001) nonred++;
      if ($countones(lt[4*p+2 -: 3]) != 1) bad = 1;
    end
    vectors++;
    if (bad || nonred > 1) begin
      miscompares++;
      $display("FAIL invariant dut%0d: lights=%h non_red=%0d, required at most 1 non-red and one of g/y/r per head",
               id, lt, nonred);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] act_l;
    logic [1:0]  act_ph;
    logic        act_pre;
    int          n;
    check_inv(2, 2, {8'h00, bus2.lights});
    check_inv(4, 4, bus4.lights);
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        n = 2; act_l = {8'h00, bus2.lights}; act_ph = {1'b0, bus2.phase}; act_pre = bus2.preempt;
      end else begin
        n = 4; act_l = bus4.lights; act_ph = bus4.phase; act_pre = bus4.preempt;
      end
      vectors++;
      if (act_l !== exp_lights(n, e.st, e.ph) || act_ph !== 2'(e.ph) || act_pre !== e.pre) begin
        miscompares++;
        $display("FAIL vec%0d dut%0d: lights=%h phase=%0d preempt=%b, required lights=%h phase=%0d preempt=%b",
                 vectors, n, act_l, act_ph, act_pre, exp_lights(n, e.st, e.ph), e.ph, e.pre);
      end
    end
  end

  task automatic push(input int st, input int ph, input bit pre);
    exp_t x;
    x.dut = cur; x.st = st; x.ph = ph; x.pre = pre;
    q.push_back(x);
  endtask

  // Drive emergency for this cycle and queue the outputs expected in this cycle
  task automatic step(input logic [3:0] em, input int st, input int ph, input bit pre);
    @(posedge clk);
    #1;
    if (cur == 0) bus2.emergency = em[1:0];
    else          bus4.emergency = em;
    push(st, ph, pre);
  endtask

  task automatic seg(input logic [3:0] em, input int st, input int ph, input bit pre, input int n);
    repeat (n) step(em, st, ph, pre);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    if (cur == 0) rst2_n = 1'b1;
    else          rst4_n = 1'b1;
    push(L, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    rst2_n = 1'b0;
    rst4_n = 1'b0;
    bus2.emergency = '0;
    bus4.emergency = '0;

    // Two approaches: reset, then two full rotations' worth of normal sequencing
    cur = 0;
    step(0, L, 0, 0);
    release_reset();
    seg(0, L, 0, 0, 4); seg(0, G, 0, 0, 10); seg(0, Y, 0, 0, 3); seg(0, C, 0, 0, 1);
    seg(0, L, 1, 0, 5); seg(0, G, 1, 0, 10); seg(0, Y, 1, 0, 3); seg(0, C, 1, 0, 1);
    seg(0, L, 0, 0, 5);

    // One-cycle request for approach 1 during phase 0 green
    seg(0, G, 0, 0, 3);
    step(2, G, 0, 0);
    step(0, G, 0, 1);
    seg(0, Y, 0, 1, 3); seg(0, C, 0, 1, 1);
    seg(0, P, 1, 1, 1); seg(0, Y, 1, 1, 3); seg(0, C, 1, 1, 1);

    // Request for the owning approach held 20 cycles during left-turn
    step(1, L, 0, 0);
    step(1, L, 0, 1);
    seg(1, P, 0, 1, 18);
    step(0, P, 0, 1);
    seg(0, Y, 0, 1, 3); seg(0, C, 0, 1, 1); seg(0, L, 1, 0, 3);

    // Asynchronous reset landing mid-preemption
    step(2, L, 1, 0);
    step(2, L, 1, 1);
    seg(2, P, 1, 1, 2);
    @(posedge clk);
    #2;
    rst2_n = 1'b0;
    bus2.emergency = '0;
    push(L, 0, 0);
    step(0, L, 0, 0);
    release_reset();
    seg(0, L, 0, 0, 4); seg(0, G, 0, 0, 2);

    // Four approaches: two requests during phase 1 yellow, chained service
    cur = 1;
    step(0, L, 0, 0);
    release_reset();
    seg(0, L, 0, 0, 4); seg(0, G, 0, 0, 10); seg(0, Y, 0, 0, 3); seg(0, C, 0, 0, 1);
    seg(0, L, 1, 0, 5); seg(0, G, 1, 0, 10);
    step(0, Y, 1, 0);
    step(4'hC, Y, 1, 0);
    step(4'hC, Y, 1, 1);
    step(4'hC, C, 1, 1);
    step(4'hC, P, 2, 1);
    step(4'h8, P, 2, 1);
    seg(4'h8, Y, 2, 1, 3);
    step(4'h8, C, 2, 1);
    step(4'h8, P, 3, 1);
    step(0, P, 3, 1);
    seg(0, Y, 3, 1, 3); step(0, C, 3, 1);
    seg(0, L, 0, 0, 2);

    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Parametrised multi-phase intersection controller; successor to the single-direction fixed-timing traffic light. It rotates right-of-way across `N_PHASES` approaches with configurable dwell times, inserts an all-red clearance interval between phases, and supports per-approach emergency pre-emption with orderly yellow/clear hand-off and resumption. It is the top-level light sequencer driving every signal head of one intersection.

## Interface
- `N_PHASES`, 2: number of approaches served in rotation (≥2).
- `LEFT_CYC`, 5: cycles of left-turn+red at phase start (≥1).
- `GREEN_CYC`, 10: cycles of green (≥1).
- `YELLOW_CYC`, 3: cycles of yellow (≥1).
- `CLEAR_CYC`, 1: cycles of all-red clearance after yellow (≥1).
- `CNT_W`, 5: dwell counter width; must hold max(dwell)−1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `emergency`  in  N_PHASES  bit p = emergency vehicle on approach p; level-sensitive.
- `lights`  out  4*N_PHASES  nibble p = {left, green, yellow, red} for approach p.
- `phase`  out  max(1,$clog2(N_PHASES))  approach currently owning right-of-way.
- `preempt`  out  1  high while a pre-emption is pending or being served.

## Operation
- States: LEFT, GREEN, YELLOW, CLEAR, PREEMPT. Registers: state, phase, dwell counter, pend flag, target.
- Dwell counter increments each cycle in a state; at count == DUR−1 the state advances and counter returns to 0. PREEMPT does not count.
- Normal rotation for phase p: LEFT → GREEN → YELLOW → CLEAR → LEFT of phase (p+1) mod N_PHASES (wrap N_PHASES−1 → 0).
- Light decode (Moore, from registered state): owning approach LEFT=1001, GREEN=0100, YELLOW=0010, CLEAR=0001, PREEMPT=0100; every non-owning approach 0001. Never two approaches non-red.
- Pre-emption request: any `emergency` bit high while pend=0 and state≠PREEMPT sets pend=1 and latches target = lowest set index. Target then fixed until PREEMPT exits.
- With pend=1: in LEFT/GREEN and phase==target → PREEMPT next cycle. In LEFT/GREEN and phase≠target → YELLOW (counter 0), normal YELLOW and CLEAR durations, then PREEMPT with phase=target. In YELLOW/CLEAR → finish normally, then PREEMPT with phase=target.
- Entering PREEMPT clears pend. PREEMPT holds while `emergency[target]`=1; minimum one cycle even if request already dropped. On drop: YELLOW, CLEAR, then LEFT of (target+1) mod N_PHASES.
- At CLEAR exit, if any `emergency` bit is high, the new lowest index is latched and served directly (CLEAR → PREEMPT), skipping LEFT.
- `preempt` = pend | (state==PREEMPT) | (post-preemption YELLOW/CLEAR).

## Timing
- Reset (async assert, any time incl. mid-preemption): state=LEFT, phase=0, counter=0, pend=0; `lights` = 1001 on approach 0, 0001 on all others; `phase`=0; `preempt`=0. First advance on first rising edge after `rst_n` deasserts.
- Defaults: phase 0 LEFT cycles 0–4, GREEN 5–14, YELLOW 15–17, CLEAR 18; phase 1 LEFT at cycle 19; full rotation 19·N_PHASES cycles.
- `emergency` sampled on rising edge; the earliest light change is on the following edge (one-cycle latency).
- Outputs change only on clock edges; no combinational path from `emergency` to `lights`.

## Structure
- Package `intersection_pkg`: state enum, light nibble constants (LIGHT_LEFT, LIGHT_GREEN, LIGHT_YELLOW, LIGHT_RED), lowest-set-bit priority function.
- One sub-module `dwell_timer`: loadable CNT_W counter with `clear`, `en`, and `done` (count == dur−1), with the duration selected by the parent.

## Test plan
- Reset, no emergency, defaults, N_PHASES=2 → phase 0 LEFT/GREEN/YELLOW/CLEAR at 5/10/3/1 cycles; phase 1 LEFT at cycle 19; back to phase 0 at cycle 38.
- `emergency`=2'b10 for 1 cycle during phase 0 GREEN → yellow 3, clear 1, approach 1 green for 1 cycle, yellow 3, clear 1, then phase 0 LEFT; `preempt` high throughout.
- `emergency`=2'b01 held 20 cycles during phase 0 LEFT → approach 0 green next cycle, held until drop, then YELLOW, CLEAR, phase 1 LEFT.
- N_PHASES=4, `emergency`=4'b1100 during phase 1 YELLOW → finish yellow and clear, PREEMPT approach 2; bit 3 still high at post-preemption CLEAR exit → PREEMPT approach 3 directly.
- `rst_n` low mid-PREEMPT → lights 1001/0001…, `preempt`=0, immediately and asynchronously; normal rotation restarts from phase 0.
- Every cycle of every test: at most one approach nibble ≠ 0001; exactly one bit of {green, yellow, red} is set per nibble.
